// File: rtl/ddr_burst_bridge.sv
// Width-converting DDR bridge: one 512-bit line (or a single 64-bit access) in, 64-bit pipelined beats out.
// Optional build macro DDR_BRIDGE_CWF_EN issues burst reads critical-word-first with wrap-around.
module ddr_burst_bridge #(
  parameter int LINE_W = 512,
  parameter int MEM_DW = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ddr_chip_enable,
  input  logic [ADDR_W-1:0] ddr_index,
  input  logic              ddr_write_enable,
  input  logic              ddr_burst_mode,
  input  logic [LINE_W-1:0] ddr_write_data,
  output logic [LINE_W-1:0] ddr_read_data,
  output logic              ddr_operation_done,
  output logic              ddr_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [MEM_DW-1:0] mem_rdata
);

  localparam int BEATS   = LINE_W / MEM_DW;
  localparam int LANE_W  = $clog2(BEATS);
  localparam int BYTE_W  = $clog2(MEM_DW / 8);
  localparam int LINE_BW = LANE_W + BYTE_W;
  localparam logic [3:0] BEATS_N = 4'(BEATS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [ADDR_W-1:BYTE_W] r_index;
  logic                 r_we;
  logic                 r_burst;
  logic [LINE_W-1:0]    r_wdata;
  logic [LINE_W-1:0]    r_rdata;
  logic [3:0]           r_issueCnt;
  logic [3:0]           r_respCnt;

  logic [3:0]           w_beatsN;
  logic [3:0]           w_respCntNext;
  logic                 w_accept;
  logic                 w_issueLast;
  logic                 w_respFire;
  logic                 w_respAll;
  logic [LANE_W-1:0]    w_startLane;
  logic [LANE_W-1:0]    w_issueLane;
  logic [LANE_W-1:0]    w_respLane;
  logic                 w_unusedIdx;

  // Byte offset within a beat never reaches the memory side.
  assign w_unusedIdx = ^ddr_index[BYTE_W-1:0];

`ifdef DDR_BRIDGE_CWF_EN
  assign w_startLane = (r_burst && !r_we) ? r_index[LINE_BW-1:BYTE_W] : '0;
`else
  assign w_startLane = '0;
`endif

  // Responses come back in issue order, so both counters map to lanes through the same start offset.
  assign w_issueLane   = w_startLane + r_issueCnt[LANE_W-1:0];
  assign w_respLane    = w_startLane + r_respCnt[LANE_W-1:0];
  assign w_beatsN      = r_burst ? BEATS_N : 4'd1;
  assign w_accept      = (r_state == IDLE) && ddr_chip_enable;
  assign w_issueLast   = (r_issueCnt == (w_beatsN - 4'd1));
  assign w_respFire    = mem_rvalid && ((r_state == ISSUE) || (r_state == WAIT));
  assign w_respCntNext = r_respCnt + {3'd0, w_respFire};
  assign w_respAll     = (w_respCntNext == w_beatsN);

  assign ddr_ready          = (r_state == IDLE);
  assign ddr_operation_done = (r_state == DONE);
  assign ddr_read_data      = r_rdata;
  assign mem_req_valid      = (r_state == ISSUE);
  assign mem_we             = r_we;
  assign mem_wdata          = r_wdata[int'(w_issueLane)*MEM_DW +: MEM_DW];
  assign mem_addr           = r_burst ? {r_index[ADDR_W-1:LINE_BW], w_issueLane, {BYTE_W{1'b0}}}
                                      : {r_index, {BYTE_W{1'b0}}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (ddr_chip_enable) w_nextState = ISSUE;
      ISSUE: if (mem_req_ready && w_issueLast) w_nextState = w_respAll ? DONE : WAIT;
      WAIT:  if (w_respAll) w_nextState = DONE;
      DONE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_index    <= '0;
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_issueCnt <= '0;
      r_respCnt  <= '0;
    end else if (w_accept) begin
      r_index    <= ddr_index[ADDR_W-1:BYTE_W];
      r_we       <= ddr_write_enable;
      r_burst    <= ddr_burst_mode;
      r_wdata    <= ddr_write_data;
      r_rdata    <= '0;
      r_issueCnt <= '0;
      r_respCnt  <= '0;
    end else begin
      if ((r_state == ISSUE) && mem_req_ready) begin
        r_issueCnt <= r_issueCnt + 4'd1;
      end
      if (w_respFire) begin
        r_respCnt <= w_respCntNext;
        if (!r_we) begin
          r_rdata[int'(w_respLane)*MEM_DW +: MEM_DW] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_bridge.sv
// Self-checking bench for ddr_burst_bridge: directed vector table, reset-abort sequence and
// randomized transactions against a line-level memory model with an in-order responder.
module tb_ddr_burst_bridge;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ddr_chip_enable = 1'b0;
  logic [63:0]  ddr_index = '0;
  logic         ddr_write_enable = 1'b0;
  logic         ddr_burst_mode = 1'b0;
  logic [511:0] ddr_write_data = '0;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_addr;
  logic         mem_we;
  logic [63:0]  mem_wdata;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;

  ddr_burst_bridge dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_addr           (mem_addr),
    .mem_we             (mem_we),
    .mem_wdata          (mem_wdata),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    int          readyCycle;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    logic [63:0] idx;
    logic        we;
    logic        burst;
    int          rdyMode;
    int          lat;
    logic        strobe;
    int          wdPattern;
    int          expCycles;
  } vec_t;

  beat_t       beatLog[$];
  resp_t       respQ[$];
  logic [63:0] memImg[logic [63:0]];
  int          readyMode = 0;
  int          latency = 1;
  logic        jitter = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[9];

  function automatic logic [63:0] memRead(input logic [63:0] a);
    if (memImg.exists(a)) return memImg[a];
    return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
  endfunction

  function automatic void checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Memory responder: handshakes and responses are decided mid-cycle; responses return in order.
  initial begin
    resp_t       r;
    beat_t       b;
    logic        stallPending;
    logic [63:0] stallAddr;
    logic [63:0] stallData;
    logic        stallWe;
    stallPending = 1'b0;
    stallAddr = '0;
    stallData = '0;
    stallWe = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (respQ.size() > 0 && respQ[0].readyCycle <= cyc) begin
        r = respQ.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata = r.data;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      case (readyMode)
        0: mem_req_ready = 1'b1;
        1: mem_req_ready = 1'($urandom_range(0, 1));
        default: mem_req_ready = 1'(cyc % 2);
      endcase
      if (stallPending && mem_req_valid) begin
        checkOutput("stall_hold", {mem_we, mem_addr, mem_wdata}, {stallWe, stallAddr, stallData});
      end
      stallPending = 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        b.addr = mem_addr;
        b.we = mem_we;
        b.wdata = mem_wdata;
        beatLog.push_back(b);
        r.readyCycle = cyc + latency + (jitter ? int'($urandom_range(0, 2)) : 0);
        r.data = mem_we ? {$urandom, $urandom} : memRead(mem_addr);
        if (mem_we) memImg[mem_addr] = mem_wdata;
        respQ.push_back(r);
      end else if (mem_req_valid) begin
        stallPending = 1'b1;
        stallAddr = mem_addr;
        stallData = mem_wdata;
        stallWe = mem_we;
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 512'(ddr_ready), 512'(1));
    checkOutput({tag, "_done"}, 512'(ddr_operation_done), 512'(0));
    checkOutput({tag, "_rdata"}, ddr_read_data, 512'(0));
    checkOutput({tag, "_valid"}, 512'(mem_req_valid), 512'(0));
    checkOutput({tag, "_memsig"}, {mem_addr, mem_we, mem_wdata}, 512'(0));
  endtask

  // One complete transaction, checked against the line-level model.
  task automatic applyStimulus(input logic [63:0] idx, input logic we, input logic burst,
                               input logic [511:0] wd, input logic strobeBusy,
                               input int expCycles, input string name);
    beat_t        expBeats[$];
    beat_t        b;
    logic [511:0] expLine;
    logic [63:0]  base;
    int           n;
    int           start;
    int           lane;
    int           waited;
    int           cycles;
    logic         seenDone;

    base = idx & ~64'h3F;
    n = burst ? 8 : 1;
    start = 0;
`ifdef DDR_BRIDGE_CWF_EN
    if (burst && !we) start = int'(idx[5:3]);
`endif
    for (int j = 0; j < n; j++) begin
      lane = (start + j) % 8;
      b.addr = burst ? base + 64'(8 * lane) : (idx & ~64'h7);
      b.we = we;
      b.wdata = wd[64*lane +: 64];
      expBeats.push_back(b);
    end
    expLine = '0;
    if (!we) begin
      for (int i = 0; i < n; i++) begin
        expLine[64*i +: 64] = memRead(burst ? base + 64'(8 * i) : (idx & ~64'h7));
      end
    end

    waited = 0;
    while (!ddr_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({name, "_ready_before"}, 512'(ddr_ready), 512'(1));

    beatLog.delete();
    ddr_chip_enable = 1'b1;
    ddr_index = idx;
    ddr_write_enable = we;
    ddr_burst_mode = burst;
    ddr_write_data = wd;

    cycles = 0;
    seenDone = 1'b0;
    while (!seenDone && cycles < 400) begin
      @(negedge clock);
      cycles++;
      if (strobeBusy) begin
        ddr_index = {$urandom, $urandom};
        ddr_write_enable = 1'($urandom_range(0, 1));
      end else begin
        ddr_chip_enable = 1'b0;
      end
      if (ddr_operation_done) seenDone = 1'b1;
    end
    ddr_chip_enable = 1'b0;
    checkOutput({name, "_done_seen"}, 512'(seenDone), 512'(1));
    if (expCycles > 0) checkOutput({name, "_done_cycle"}, 512'(cycles), 512'(expCycles));
    checkOutput({name, "_rline"}, ddr_read_data, expLine);

    @(negedge clock);
    checkOutput({name, "_done_pulse"}, 512'(ddr_operation_done), 512'(0));
    checkOutput({name, "_ready_after"}, 512'(ddr_ready), 512'(1));
    @(negedge clock);
    @(negedge clock);
    checkOutput({name, "_rline_hold"}, ddr_read_data, expLine);
    checkOutput({name, "_no_extra_done"}, 512'(ddr_operation_done), 512'(0));
    checkOutput({name, "_beat_count"}, 512'(beatLog.size()), 512'(n));
    for (int j = 0; j < n && j < beatLog.size(); j++) begin
      checkOutput({name, "_beat_addr"}, 512'(beatLog[j].addr), 512'(expBeats[j].addr));
      checkOutput({name, "_beat_we"}, 512'(beatLog[j].we), 512'(expBeats[j].we));
      if (we) checkOutput({name, "_beat_wdata"}, 512'(beatLog[j].wdata), 512'(expBeats[j].wdata));
    end
  endtask

  initial begin
    logic [511:0] wd;
    int           waited;
    logic         strayBad;

    for (int i = 0; i < 8; i++) memImg[64'h1000 + 64'(8 * i)] = 64'(8'h11 * (i + 1));
    memImg[64'h3008] = 64'hDEAD_BEEF;

    //           idx         we    burst rdy lat strobe wdp exp
    vecs[0] = '{64'h1000,   1'b0, 1'b1, 0,  1,  1'b0,  1,  10};
    vecs[1] = '{64'h2040,   1'b1, 1'b1, 0,  1,  1'b0,  0,  10};
    vecs[2] = '{64'h300C,   1'b0, 1'b0, 0,  1,  1'b0,  1,  3};
    vecs[3] = '{64'h5000,   1'b0, 1'b1, 2,  1,  1'b1,  1,  -1};
    vecs[4] = '{64'h6003,   1'b1, 1'b0, 0,  1,  1'b0,  1,  3};
    vecs[5] = '{64'h8010,   1'b0, 1'b1, 0,  3,  1'b0,  1,  12};
    vecs[6] = '{64'h1028,   1'b0, 1'b1, 0,  1,  1'b0,  1,  10};
    vecs[7] = '{64'h9028,   1'b1, 1'b1, 2,  2,  1'b1,  1,  -1};
    vecs[8] = '{64'h2058,   1'b0, 1'b1, 0,  1,  1'b0,  1,  10};

    repeat (3) @(negedge clock);
    checkResetValues("reset");
    reset_n = 1'b1;
    @(negedge clock);
    checkResetValues("post_reset");

    for (int v = 0; v < 9; v++) begin
      readyMode = vecs[v].rdyMode;
      latency = vecs[v].lat;
      jitter = 1'b0;
      for (int i = 0; i < 16; i++) begin
        wd[32*i +: 32] = (vecs[v].wdPattern == 0) ? ((i % 2 == 0) ? 32'(i / 2) : 32'd0) : $urandom;
      end
      applyStimulus(vecs[v].idx, vecs[v].we, vecs[v].burst, wd, vecs[v].strobe,
                    vecs[v].expCycles, $sformatf("vec%0d", v));
    end

    // Reset in the middle of a burst; its late responses must be dropped.
    readyMode = 0;
    latency = 4;
    beatLog.delete();
    ddr_index = 64'h7000;
    ddr_write_enable = 1'b0;
    ddr_burst_mode = 1'b1;
    ddr_chip_enable = 1'b1;
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    waited = 0;
    while (beatLog.size() < 3 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("abort_beats_issued", 512'(beatLog.size() >= 3), 512'(1));
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    checkResetValues("abort");
    reset_n = 1'b1;
    strayBad = 1'b0;
    waited = 0;
    while ((respQ.size() > 0 || waited < 3) && waited < 50) begin
      @(negedge clock);
      waited++;
      if (ddr_operation_done || !ddr_ready || ddr_read_data != '0) strayBad = 1'b1;
    end
    checkOutput("abort_stray_ignored", 512'(strayBad), 512'(0));
    latency = 1;
    applyStimulus(64'h7000, 1'b0, 1'b1, '0, 1'b0, 10, "after_abort");

    for (int t = 0; t < 30; t++) begin
      readyMode = int'($urandom_range(0, 1));
      latency = int'($urandom_range(1, 3));
      jitter = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) wd[32*i +: 32] = $urandom;
      applyStimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    wd, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/ddr_burst_bridge.md
# ddr_burst_bridge

Width-converting bridge on the core's external DDR port, directly downstream of the core's channel arbiter. Accepts one 512-bit cache-line or single 64-bit access from the core and splits it into 64-bit beats on a narrow pipelined memory interface. It reassembles read beats into a full line and signals completion back to the core with a one-cycle done pulse. One transaction is in flight at a time.

## Interface
- LINE_W, 512, line width in bits on the core side
- MEM_DW, 64, memory-side data width; BEATS = LINE_W/MEM_DW = 8
- ADDR_W, 64, byte-address width on both sides

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ddr_chip_enable  in  1  request strobe; accepted only when ddr_ready=1
- ddr_index  in  ADDR_W  byte address of request
- ddr_write_enable  in  1  1=write, 0=read
- ddr_burst_mode  in  1  1=full line (BEATS beats), 0=single beat
- ddr_write_data  in  LINE_W  write line; single-beat write uses [63:0]
- ddr_read_data  out  LINE_W  assembled read line
- ddr_operation_done  out  1  one-cycle completion pulse
- ddr_ready  out  1  bridge idle, may accept a request
- mem_req_valid  out  1  beat request valid
- mem_req_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  beat byte address, 8-byte aligned
- mem_we  out  1  beat is a write
- mem_wdata  out  MEM_DW  write beat data
- mem_rvalid  in  1  in-order response per accepted beat (reads and writes)
- mem_rdata  in  MEM_DW  read beat data; ignored for writes

## Operation
- States: IDLE, ISSUE, WAIT, DONE. ddr_ready = (state==IDLE).
- IDLE: ddr_chip_enable & ddr_ready latches index, write_enable, burst_mode and write data; clears ddr_read_data to 0; go ISSUE. Strobe while not ready is ignored (not queued).
- Beat count N = burst ? BEATS : 1. Burst base = ddr_index with [5:0] cleared; single-beat address = ddr_index with [2:0] cleared.
- ISSUE: mem_req_valid=1, holds mem_addr/mem_we/mem_wdata stable until mem_req_ready. Issue counter (4 bits) advances per handshake; after Nth handshake go WAIT (or DONE if all N responses already counted).
- Beat i of a burst: mem_addr = base + 8*i, mem_wdata = ddr_write_data[64*i +: 64].
- Responses counted in ISSUE and WAIT; read beat i written to ddr_read_data[64*i +: 64]; single read into [63:0], upper bits stay 0. Response in the same cycle as the last handshake is counted.
- WAIT: when response count reaches N go DONE.
- DONE: ddr_operation_done=1 for exactly one cycle; next state IDLE. ddr_read_data holds until the next accepted request.
- mem_rvalid in IDLE/DONE is ignored (stray or post-reset responses).
- Reset (any state, any time): state IDLE, counters 0, ddr_read_data 0, mem_req_valid 0, ddr_operation_done 0; in-flight memory responses are dropped.

## Timing
- Reset values: ddr_ready=1, ddr_operation_done=0, ddr_read_data=0, mem_req_valid=0, mem_addr=0, mem_we=0, mem_wdata=0.
- Request accepted in cycle 0; mem_req_valid first high in cycle 1.
- Memory responds no earlier than one cycle after beat acceptance.
- With mem_req_ready=1 and 1-cycle response: burst beats issued cycles 1-8, responses cycles 2-9, done pulse cycle 10, ddr_ready high cycle 11. Single beat: done cycle 3, ready cycle 4.
- Backpressure on mem_req_ready stalls issue only; latency extends by stall cycles.

## Configuration
- DDR_BRIDGE_CWF_EN: critical-word-first for burst reads. Defined: issue order starts at beat k = ddr_index[5:3] and wraps (k, k+1, …, 7, 0, …, k-1); each beat still lands in lane of its address. Not defined: burst reads always issue beat 0 first. Burst writes and single beats are identical in both builds.

## Test plan
- Burst read, index 0x1000, ready=1, rdata = 0x11*(i+1) per beat -> addrs 0x1000..0x1038 step 8, done at cycle 10, ddr_read_data lane i = 0x11*(i+1).
- Burst write, index 0x2040, data lane i = i -> 8 beats mem_we=1, addr 0x2040+8i, wdata=i, done after 8th ack.
- Single read, index 0x300C, rdata 0xDEADBEEF -> one beat at 0x3008, ddr_read_data = 0xDEADBEEF zero-extended, done cycle 3.
- mem_req_ready toggling 1/0 plus strobe while busy -> addr/data stable during stall, no extra transaction, exactly one done pulse.
- DDR_BRIDGE_CWF_EN, burst read index 0x1028 -> issue order 0x1028,0x1030,0x1038,0x1000..0x1020; line assembled in address order.
- reset_n low after 3 beats issued, pending responses arrive post-reset -> outputs at reset values, responses ignored, next request completes normally.
